// File: rtl/sram_access_arbiter_if.sv
// rtl/sram_access_arbiter_if.sv - single-word req/done handshake between a requester and a responder
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output done, rdata
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - audio-priority arbiter with CPU starvation guard in front of the SRAM engine
// Optional watchdog on stuck transactions: define SRAM_TIMEOUT_EN.
module sram_access_arbiter #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 16,
  parameter int MAX_AUD_BURST  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_access_arbiter_if.slave  aud,
  sram_access_arbiter_if.slave  cpu,
  sram_access_arbiter_if.master mem,
  output logic                  busy,
  output logic                  owner,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AUD_BUSY = 2'd1,
    CPU_BUSY = 2'd2
  } state_t;

  localparam int SC_W = (MAX_AUD_BURST < 1) ? 1 : $clog2(MAX_AUD_BURST + 1);

  state_t            state;
  logic [SC_W-1:0]   starve_cnt;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              aud_done_q;
  logic              cpu_done_q;
  logic [DATA_W-1:0] aud_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              busy_q;
  logic              owner_q;
  logic              err_q;

  logic              cpu_wins;
  logic              fin;
  logic [DATA_W-1:0] fin_data;
  logic              fin_err;

  // CPU takes the slot when audio is absent or has used up its burst allowance
  assign cpu_wins = cpu.req && (!aud.req || (starve_cnt == SC_W'(MAX_AUD_BURST)));

`ifdef SRAM_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // A real mem_done always beats a watchdog expiry on the same edge
  always_comb begin
    fin      = 1'b0;
    fin_data = mem.rdata;
    fin_err  = 1'b0;
    if (state != IDLE) begin
      if (mem.done) begin
        fin = 1'b1;
      end
`ifdef SRAM_TIMEOUT_EN
      else if (wd_expired) begin
        fin      = 1'b1;
        fin_data = '0;
        fin_err  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      aud_done_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      aud_rdata_q <= '0;
      cpu_rdata_q <= '0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef SRAM_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      aud_done_q <= 1'b0;
      cpu_done_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (aud.req || cpu.req) begin
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
`ifdef SRAM_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
            if (cpu_wins) begin
              state       <= CPU_BUSY;
              owner_q     <= 1'b1;
              mem_we_q    <= cpu.we;
              mem_addr_q  <= cpu.addr;
              mem_wdata_q <= cpu.wdata;
              starve_cnt  <= '0;
            end else begin
              state       <= AUD_BUSY;
              owner_q     <= 1'b0;
              mem_we_q    <= aud.we;
              mem_addr_q  <= aud.addr;
              mem_wdata_q <= aud.wdata;
              if (!cpu.req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != SC_W'(MAX_AUD_BURST)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
              end
            end
          end
        end
        AUD_BUSY, CPU_BUSY: begin
          if (fin) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= fin_err;
            if (state == CPU_BUSY) begin
              cpu_done_q  <= 1'b1;
              cpu_rdata_q <= fin_data;
            end else begin
              aud_done_q  <= 1'b1;
              aud_rdata_q <= fin_data;
            end
          end
`ifdef SRAM_TIMEOUT_EN
          else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;
  assign aud.done  = aud_done_q;
  assign aud.rdata = aud_rdata_q;
  assign cpu.done  = cpu_done_q;
  assign cpu.rdata = cpu_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - scoreboard bench for sram_access_arbiter with a latency-driven SRAM engine model
module tb_sram_access_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic owner;
  logic err;

  sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) aud_if ();
  sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
  sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  sram_access_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_AUD_BURST(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .aud(aud_if),
    .cpu(cpu_if),
    .mem(mem_if),
    .busy(busy),
    .owner(owner),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_cpu;
    bit          chk;
    logic [15:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  bit   grants[$];
  int   tests = 0;
  int   fails = 0;
  int   mem_lat = 4;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(bit is_cpu, bit chk, logic [15:0] rdata, bit e);
    exp_t x;
    x.is_cpu = is_cpu;
    x.chk    = chk;
    x.rdata  = rdata;
    x.err    = e;
    exp_q.push_back(x);
  endtask

  task automatic set_aud(bit r, bit we, logic [16:0] a, logic [15:0] d);
    aud_if.req   = r;
    aud_if.we    = we;
    aud_if.addr  = a;
    aud_if.wdata = d;
  endtask

  task automatic set_cpu(bit r, bit we, logic [16:0] a, logic [15:0] d);
    cpu_if.req   = r;
    cpu_if.we    = we;
    cpu_if.addr  = a;
    cpu_if.wdata = d;
  endtask

  // Hold req across n completions, then drop it in the cycle the last done is seen
  task automatic wait_done(bit is_cpu, int n, int budget);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (is_cpu ? cpu_if.done : aud_if.done) seen++;
    end
    check(is_cpu ? "cpu_done_count" : "aud_done_count", seen, n);
    if (is_cpu) set_cpu(1'b0, 1'b0, '0, '0);
    else        set_aud(1'b0, 1'b0, '0, '0);
  endtask

  // SRAM engine: completes mem_lat cycles after mem_req is seen, rdata = addr ^ 0x5A5A
  initial begin
    int cnt = 0;
    mem_if.done  = 1'b0;
    mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      mem_if.done = 1'b0;
      if (mem_if.req && !reset && mem_lat != 0) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_if.done  = 1'b1;
          mem_if.rdata = mem_if.addr[15:0] ^ 16'h5A5A;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: log grants and score every completion against the expectation queue
  initial begin
    bit   prev_req = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_if.req && !prev_req) grants.push_back(owner);
      prev_req = mem_if.req;
      if (aud_if.done && cpu_if.done) begin
        tests++;
        fails++;
        $display("FAIL both_done: aud_done=1 cpu_done=1, expected at most one");
      end else if (aud_if.done || cpu_if.done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: aud_done=%0b cpu_done=%0b with nothing expected", aud_if.done, cpu_if.done);
        end else begin
          e = exp_q.pop_front();
          check("done_owner", cpu_if.done, e.is_cpu);
          if (e.chk) check("done_rdata", e.is_cpu ? cpu_if.rdata : aud_if.rdata, e.rdata);
          check("done_err", err, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  bit exp_g[10];

  initial begin
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    set_aud(1'b0, 1'b0, '0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_if.req, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_err", err, 0);
    check("rst_done", {aud_if.done, cpu_if.done}, 0);
    check("rst_rdata", {aud_if.rdata, cpu_if.rdata}, 0);
    check("rst_mem_addr", mem_if.addr, 0);
    reset = 1'b0;

    // 1: CPU write
    @(negedge clk);
    mem_lat = 20;
    push(1'b1, 1'b0, 16'h0, 1'b0);
    set_cpu(1'b1, 1'b1, 17'h00123, 16'hBEEF);
    @(negedge clk);
    check("t1_mem_req", mem_if.req, 1);
    check("t1_mem_addr", mem_if.addr, 17'h00123);
    check("t1_mem_we", mem_if.we, 1);
    check("t1_mem_wdata", mem_if.wdata, 16'hBEEF);
    check("t1_owner", owner, 1);
    check("t1_busy", busy, 1);
    wait_done(1'b1, 1, 100);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_done_pulse", cpu_if.done, 0);
    check("t1_mem_req_after", mem_if.req, 0);

    // 2: audio read then CPU read of the top address
    mem_lat = 3;
    push(1'b0, 1'b1, 16'h5B5A, 1'b0);
    set_aud(1'b1, 1'b0, 17'h00100, 16'h0);
    wait_done(1'b0, 1, 50);
    push(1'b1, 1'b1, 16'hA5A5, 1'b0);
    set_cpu(1'b1, 1'b0, 17'h1FFFF, 16'h0);
    wait_done(1'b1, 1, 50);
    @(negedge clk);
    check("t2_cpu_rdata", cpu_if.rdata, 16'hA5A5);
    check("t2_aud_rdata_kept", aud_if.rdata, 16'h5B5A);

    // 3: simultaneous requests
    grants.delete();
    push(1'b0, 1'b1, 16'h585A, 1'b0);
    push(1'b1, 1'b0, 16'h0, 1'b0);
    set_aud(1'b1, 1'b0, 17'h00200, 16'h0);
    set_cpu(1'b1, 1'b1, 17'h00300, 16'h1234);
    @(negedge clk);
    check("t3_first_owner", owner, 0);
    fork
      wait_done(1'b0, 1, 50);
      wait_done(1'b1, 1, 100);
    join
    @(negedge clk);
    check("t3_grant_count", grants.size(), 2);
    if (grants.size() == 2) check("t3_grant_order", {grants[0], grants[1]}, 2'b01);

    // 4: audio held with CPU pending, two starvation rounds
    grants.delete();
    mem_lat = 2;
    for (int i = 0; i < 10; i++) begin
      if (exp_g[i]) push(1'b1, 1'b1, 16'h5A7A, 1'b0);
      else          push(1'b0, 1'b1, 16'h5A4A, 1'b0);
    end
    set_aud(1'b1, 1'b0, 17'h00010, 16'h0);
    set_cpu(1'b1, 1'b0, 17'h00020, 16'h0);
    fork
      wait_done(1'b0, 8, 400);
      wait_done(1'b1, 2, 400);
    join
    @(negedge clk);
    check("t4_grant_count", grants.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < grants.size()) check($sformatf("t4_grant_%0d", i), grants[i], exp_g[i]);
    end

    // 5: reset in the middle of an audio read
    mem_lat = 20;
    set_aud(1'b1, 1'b0, 17'h00055, 16'h0);
    @(negedge clk);
    check("t5_granted", mem_if.req, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    set_aud(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_mem_req_drop", mem_if.req, 0);
    check("t5_busy_drop", busy, 0);
    check("t5_no_aud_done", aud_if.done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_idle", busy, 0);
    mem_lat = 3;
    push(1'b0, 1'b1, 16'h5A0F, 1'b0);
    set_aud(1'b1, 1'b0, 17'h00055, 16'h0);
    @(negedge clk);
    check("t5_regrant", mem_if.req, 1);
    check("t5_regrant_owner", owner, 0);
    wait_done(1'b0, 1, 50);

    // 6: engine never answers
    @(negedge clk);
    mem_lat = 0;
`ifdef SRAM_TIMEOUT_EN
    begin
      int n = 0;
      push(1'b1, 1'b1, 16'h0000, 1'b1);
      set_cpu(1'b1, 1'b0, 17'h00777, 16'h0);
      while (!cpu_if.done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("t6_timeout_cycle", n, 17);
      check("t6_mem_req", mem_if.req, 0);
      check("t6_busy", busy, 0);
      set_cpu(1'b0, 1'b0, '0, '0);
    end
`else
    set_cpu(1'b1, 1'b0, 17'h00777, 16'h0);
    repeat (2100) @(negedge clk);
    check("t6_busy_held", busy, 1);
    check("t6_mem_req_held", mem_if.req, 1);
    check("t6_owner", owner, 1);
    check("t6_err", err, 0);
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
